noc_flit_tx: RTL and testbench
==============================

Name: noc_flit_tx

Overview:
- Transmit-side network interface for the minimal NoC: drains payload words from the local same-clock write FIFO and sends them onto the router injection link as head/body/tail flits.
- A local command (destination, length) starts each packet.
- The head flit is generated internally. Body and tail flits pop FIFO words, which the FIFO presents first-word-fall-through.
- The link uses a valid/ready handshake with a registered output stage.

Parameters:
- DATA_W, 32, payload word width; must match the FIFO data width.
- ADDR_W, 4, node address width.
- LEN_W, 4, packet length field width.
- MAX_LEN, 8, maximum payload words per packet (1..2^LEN_W-1).
- NODE_ID, 0, source address inserted in head flits.
- Constraint: 2*ADDR_W+LEN_W <= DATA_W.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- pkt_start  in  1  one-cycle command strobe.
- pkt_dest  in  ADDR_W  destination node, sampled with pkt_start.
- pkt_len  in  LEN_W  payload word count, sampled with pkt_start.
- pkt_busy  out  1  packet in progress.
- fifo_data  in  DATA_W  FIFO head word (valid when fifo_empty=0).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop; combinational.
- flit_out  out  DATA_W+2  {type[1:0], payload}.
- flit_valid  out  1  flit_out valid.
- flit_ready  in  1  router accepts flit.
- error  out  1  one-cycle pulse on a rejected command.

Behaviour:
- **Reset** (sampled on the clk edge while reset=1):
  - state=IDLE, flit_valid=0, flit_out=0, pkt_busy=0, error=0, counters=0.
  - fifo_rd_en=0 whenever reset=1.
  - Reset mid-packet abandons the packet. FIFO contents are not touched, and no tail is sent.
- **Flit types:**
  - 2'b01 head: payload [ADDR_W-1:0]=dest, [2*ADDR_W-1:ADDR_W]=NODE_ID, [2*ADDR_W+LEN_W-1:2*ADDR_W]=len, remaining bits 0.
  - 2'b00 body.
  - 2'b10 tail.
  - 2'b11 unused.
- **States:** IDLE, SEND.
- **IDLE:**
  - On pkt_start with 1<=pkt_len<=MAX_LEN: latch dest/len, fetch_cnt<=0.
  - On that same edge: load the head flit, flit_valid<=1, state<=SEND. Latency is 1 cycle from pkt_start to head valid.
  - pkt_len=0 or pkt_len>MAX_LEN: error<=1 for one cycle, stay IDLE.
- **pkt_busy:** equals (state==SEND).
- **SEND:**
  - slot_free = ~flit_valid | flit_ready.
  - fifo_rd_en = slot_free & ~fifo_empty & (fetch_cnt<len).
  - When fifo_rd_en=1: flit_out<={type, fifo_data}, flit_valid<=1, fetch_cnt<=fetch_cnt+1. Type is tail if fetch_cnt==len-1, else body.
  - When flit_valid & flit_ready and no load occurs: flit_valid<=0.
  - On the tail handshake (flit_valid & flit_ready & type==tail): state<=IDLE, pkt_busy falls next cycle.
- **Throughput:** 1 flit/cycle while flit_ready=1 and the FIFO is non-empty. The head handshake and the first body load occur on the same edge.
- **Hold rule:** while flit_valid=1 and flit_ready=0, flit_out and flit_valid are held stable and fifo_rd_en=0.
- **FIFO empty mid-packet:** flit_valid drops after the current flit is accepted; the packet resumes when the FIFO refills. No timeout.
- **Command while busy:** pkt_start in SEND is ignored and pulses error; the packet is unaffected. pkt_start on the cycle after tail acceptance (state IDLE) is accepted.
- **Pop limit:** fifo_rd_en is never asserted while fifo_empty=1 or after len words have been popped. A FIFO underflow error is therefore impossible.
- **Counter width:** fetch_cnt is LEN_W bits; no wrap is possible since len<=MAX_LEN.

Test Plan:
1. **Basic packet:** reset; FIFO holds 3 words A1,A2,A3; pkt_start dest=5 len=3; flit_ready=1 → cycle+1 head {01, len=3, src=0, dest=5}, then 00/A1, 00/A2, 10/A3 on consecutive cycles. Exactly 3 fifo_rd_en pulses; pkt_busy low the cycle after the tail.
2. **Backpressure:** as scenario 1 but flit_ready=0 for 4 cycles after head valid → head held unchanged, fifo_rd_en=0 throughout; the stream resumes intact once ready=1.
3. **FIFO starvation:** FIFO holds 1 word, len=3; push the remaining 2 words 5 cycles later → flit_valid gaps while empty; the final flit is the tail carrying word 3; no extra pops.
4. **Illegal commands:** pkt_len=0 → error pulse, no head; pkt_len=9 (MAX_LEN=8) → error pulse; pkt_start during SEND → error pulse, in-flight packet unchanged.
5. **Single-word and back-to-back:** len=1 → head then 10/word. A second pkt_start the cycle after tail acceptance → its head appears the following cycle.
6. **Reset mid-packet:** assert reset after the 2nd body flit of len=5 → next cycle flit_valid=0, pkt_busy=0, fifo_rd_en=0; a new len=2 packet then sends correctly.

Source files
------------

// File: rtl/noc_flit_tx.sv
// NoC transmit NI: head flit built from the command, body/tail flits popped from an FWFT FIFO.
// Head valid 1 cycle after pkt_start; 1 flit/cycle; flit_ready=0 holds the output register and stops FIFO pops.
module noc_flit_tx #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int LEN_W   = 4,
    parameter int MAX_LEN = 8,
    parameter int NODE_ID = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_start,
    input  logic [ADDR_W-1:0]   pkt_dest,
    input  logic [LEN_W-1:0]    pkt_len,
    output logic                pkt_busy,
    input  logic [DATA_W-1:0]   fifo_data,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    output logic [DATA_W+1:0]   flit_out,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic                error
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [1:0]       T_HEAD    = 2'b01;
    localparam logic [1:0]       T_BODY    = 2'b00;
    localparam logic [1:0]       T_TAIL    = 2'b10;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    fetch_cnt_q, fetch_cnt_d;
    logic [DATA_W+1:0]   flit_out_q, flit_out_d;
    logic                flit_valid_q, flit_valid_d;
    logic                error_q, error_d;

    logic                len_ok;
    logic                cmd_accept;
    logic                slot_free;
    logic                pop;
    logic                is_last;
    logic                tail_hs;
    logic [DATA_W-1:0]   head_pl;

    assign len_ok     = (pkt_len != '0) && (pkt_len <= MAX_LEN_L);
    assign cmd_accept = (state_q == IDLE) && pkt_start && len_ok;
    assign slot_free  = ~flit_valid_q | flit_ready;
    assign is_last    = (fetch_cnt_q == (len_q - LEN_W'(1)));
    assign tail_hs    = flit_valid_q && flit_ready && (flit_out_q[DATA_W+1:DATA_W] == T_TAIL);
    // Pop only into a free slot and never beyond the packet length.
    assign pop        = ~reset && (state_q == SEND) && slot_free && ~fifo_empty
                        && (fetch_cnt_q < len_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_accept) state_d = SEND;
            SEND:    if (tail_hs)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt_busy   = (state_q == SEND);
        fifo_rd_en = pop;
        flit_out   = flit_out_q;
        flit_valid = flit_valid_q;
        error      = error_q;
    end

    always_comb begin
        head_pl                                 = '0;
        head_pl[ADDR_W-1:0]                     = pkt_dest;
        head_pl[2*ADDR_W-1:ADDR_W]              = ADDR_W'(NODE_ID);
        head_pl[2*ADDR_W+LEN_W-1:2*ADDR_W]      = pkt_len;
    end

    always_comb begin
        len_d        = len_q;
        fetch_cnt_d  = fetch_cnt_q;
        flit_out_d   = flit_out_q;
        flit_valid_d = flit_valid_q;
        error_d      = pkt_start && ((state_q == SEND) || ~len_ok);
        if (cmd_accept) begin
            len_d        = pkt_len;
            fetch_cnt_d  = '0;
            flit_out_d   = {T_HEAD, head_pl};
            flit_valid_d = 1'b1;
        end else if (pop) begin
            flit_out_d   = {(is_last ? T_TAIL : T_BODY), fifo_data};
            flit_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + LEN_W'(1);
        end else if (flit_valid_q && flit_ready) begin
            flit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            fetch_cnt_q  <= '0;
            flit_out_q   <= '0;
            flit_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            len_q        <= len_d;
            fetch_cnt_q  <= fetch_cnt_d;
            flit_out_q   <= flit_out_d;
            flit_valid_q <= flit_valid_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_tx.sv
// Directed bench for noc_flit_tx: FWFT FIFO model plus a queue of expected flits checked on each handshake.
module tb_noc_flit_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_start;
    logic [3:0]  pkt_dest;
    logic [3:0]  pkt_len;
    logic        pkt_busy;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        error;

    always #5 clk = ~clk;

    noc_flit_tx #(.DATA_W(32), .ADDR_W(4), .LEN_W(4), .MAX_LEN(8), .NODE_ID(0)) dut (
        .clk(clk), .reset(reset), .pkt_start(pkt_start), .pkt_dest(pkt_dest),
        .pkt_len(pkt_len), .pkt_busy(pkt_busy), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .flit_out(flit_out),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .error(error)
    );

    // FWFT FIFO model: the bench writes mem/wr_ptr, pops advance rd_ptr on the clock edge.
    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;

    always @(posedge clk) if (fifo_rd_en === 1'b1) rd_ptr <= rd_ptr + 8'd1;

    assign fifo_data  = mem[rd_ptr];
    assign fifo_empty = (rd_ptr == wr_ptr);

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: compare any handshake at mid-cycle, then step to 1 time unit after the edge.
    task automatic tick();
        @(negedge clk);
        if (flit_valid === 1'b1 && flit_ready && !reset) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_flit: observed %0h expected none", flit_out);
            end else begin
                chk("flit", {30'b0, flit_out}, {30'b0, exp_q.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    function automatic logic [33:0] head_flit(input logic [3:0] d, input logic [3:0] l);
        logic [31:0] p;
        p        = '0;
        p[3:0]   = d;
        p[7:4]   = 4'd0;
        p[11:8]  = l;
        return {2'b01, p};
    endfunction

    task automatic cmd(input logic [3:0] d, input logic [3:0] l);
        pkt_dest  = d;
        pkt_len   = l;
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int          cyc;
        logic [7:0]  base;

        reset = 1'b1; pkt_start = 1'b0; pkt_dest = '0; pkt_len = '0; flit_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(flit_valid), 64'd0);
        chk("rst_flit",  64'(flit_out),   64'd0);
        chk("rst_busy",  64'(pkt_busy),   64'd0);
        chk("rst_error", 64'(error),      64'd0);
        chk("rst_rden",  64'(fifo_rd_en), 64'd0);
        reset = 1'b0;
        tick();

        // Basic packet
        base = rd_ptr;
        flit_ready = 1'b1;
        push(32'hA1A1_0001); push(32'hA2A2_0002); push(32'hA3A3_0003);
        exp_q.push_back(head_flit(4'd5, 4'd3));
        exp_q.push_back({2'b00, 32'hA1A1_0001});
        exp_q.push_back({2'b00, 32'hA2A2_0002});
        exp_q.push_back({2'b10, 32'hA3A3_0003});
        cmd(4'd5, 4'd3);
        chk("t1_head_lat", 64'(flit_valid), 64'd1);
        chk("t1_busy",     64'(pkt_busy),   64'd1);
        drain(cyc);
        chk("t1_cycles",   64'(cyc),        64'd4);
        chk("t1_busy_end", 64'(pkt_busy),   64'd0);
        chk("t1_pops",     64'(rd_ptr - base), 64'd3);

        // Backpressure on the head
        base = rd_ptr;
        flit_ready = 1'b0;
        push(32'hB1B1_0001); push(32'hB2B2_0002); push(32'hB3B3_0003);
        exp_q.push_back(head_flit(4'd5, 4'd3));
        exp_q.push_back({2'b00, 32'hB1B1_0001});
        exp_q.push_back({2'b00, 32'hB2B2_0002});
        exp_q.push_back({2'b10, 32'hB3B3_0003});
        cmd(4'd5, 4'd3);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_flit",  64'(flit_out),   64'(head_flit(4'd5, 4'd3)));
            chk("t2_hold_valid", 64'(flit_valid), 64'd1);
            chk("t2_hold_rden",  64'(fifo_rd_en), 64'd0);
            tick();
        end
        flit_ready = 1'b1;
        drain(cyc);
        chk("t2_pops", 64'(rd_ptr - base), 64'd3);
        chk("t2_busy", 64'(pkt_busy), 64'd0);

        // FIFO starvation mid-packet
        base = rd_ptr;
        push(32'hC1C1_0001);
        exp_q.push_back(head_flit(4'd6, 4'd3));
        exp_q.push_back({2'b00, 32'hC1C1_0001});
        exp_q.push_back({2'b00, 32'hC2C2_0002});
        exp_q.push_back({2'b10, 32'hC3C3_0003});
        cmd(4'd6, 4'd3);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_gap_valid", 64'(flit_valid), 64'd0);
        chk("t3_gap_rden",  64'(fifo_rd_en), 64'd0);
        chk("t3_gap_busy",  64'(pkt_busy),   64'd1);
        chk("t3_gap_pops",  64'(rd_ptr - base), 64'd1);
        push(32'hC2C2_0002); push(32'hC3C3_0003);
        drain(cyc);
        chk("t3_pops", 64'(rd_ptr - base), 64'd3);
        tick();
        chk("t3_no_extra", 64'(rd_ptr - base), 64'd3);

        // Illegal commands
        cmd(4'd2, 4'd0);
        chk("t4_len0_err",   64'(error),      64'd1);
        chk("t4_len0_valid", 64'(flit_valid), 64'd0);
        chk("t4_len0_busy",  64'(pkt_busy),   64'd0);
        tick();
        chk("t4_err_pulse",  64'(error),      64'd0);
        cmd(4'd2, 4'd9);
        chk("t4_len9_err",   64'(error),      64'd1);
        chk("t4_len9_valid", 64'(flit_valid), 64'd0);
        tick();
        base = rd_ptr;
        flit_ready = 1'b0;
        push(32'hD1D1_0001); push(32'hD2D2_0002);
        exp_q.push_back(head_flit(4'd4, 4'd2));
        exp_q.push_back({2'b00, 32'hD1D1_0001});
        exp_q.push_back({2'b10, 32'hD2D2_0002});
        cmd(4'd4, 4'd2);
        chk("t4_busy_ok_err", 64'(error), 64'd0);
        cmd(4'd3, 4'd4);
        chk("t4_busy_err",  64'(error),    64'd1);
        chk("t4_busy_flit", 64'(flit_out), 64'(head_flit(4'd4, 4'd2)));
        chk("t4_busy_busy", 64'(pkt_busy), 64'd1);
        flit_ready = 1'b1;
        drain(cyc);
        chk("t4_pops", 64'(rd_ptr - base), 64'd2);

        // Single word then back-to-back packet
        base = rd_ptr;
        push(32'hE1E1_0001);
        exp_q.push_back(head_flit(4'd1, 4'd1));
        exp_q.push_back({2'b10, 32'hE1E1_0001});
        cmd(4'd1, 4'd1);
        drain(cyc);
        chk("t5_len1_cycles", 64'(cyc), 64'd2);
        chk("t5_idle", 64'(pkt_busy), 64'd0);
        push(32'hF1F1_0001); push(32'hF2F2_0002);
        exp_q.push_back(head_flit(4'd7, 4'd2));
        exp_q.push_back({2'b00, 32'hF1F1_0001});
        exp_q.push_back({2'b10, 32'hF2F2_0002});
        cmd(4'd7, 4'd2);
        chk("t5_b2b_valid", 64'(flit_valid), 64'd1);
        chk("t5_b2b_head",  64'(flit_out),   64'(head_flit(4'd7, 4'd2)));
        chk("t5_b2b_err",   64'(error),      64'd0);
        drain(cyc);
        chk("t5_pops", 64'(rd_ptr - base), 64'd3);

        // Reset mid-packet, leftover words go to the next packet
        base = rd_ptr;
        for (int i = 1; i <= 5; i++) push(32'h6000_0000 + 32'(i));
        exp_q.push_back(head_flit(4'd8, 4'd5));
        exp_q.push_back({2'b00, 32'h6000_0001});
        exp_q.push_back({2'b00, 32'h6000_0002});
        cmd(4'd8, 4'd5);
        tick();
        tick();
        tick();
        chk("t6_pre_left", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        #1;
        chk("t6_rden_rst", 64'(fifo_rd_en), 64'd0);
        chk("t6_pops_rst", 64'(rd_ptr - base), 64'd3);
        tick();
        chk("t6_valid", 64'(flit_valid), 64'd0);
        chk("t6_busy",  64'(pkt_busy),   64'd0);
        chk("t6_flit",  64'(flit_out),   64'd0);
        chk("t6_rden",  64'(fifo_rd_en), 64'd0);
        reset = 1'b0;
        tick();
        exp_q.push_back(head_flit(4'd9, 4'd2));
        exp_q.push_back({2'b00, 32'h6000_0004});
        exp_q.push_back({2'b10, 32'h6000_0005});
        cmd(4'd9, 4'd2);
        drain(cyc);
        chk("t6_pops", 64'(rd_ptr - base), 64'd5);
        chk("t6_busy_end", 64'(pkt_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
